instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
Streaming RV32I instruction encoder and program loader. Accepts one instruction per handshake as a format select plus register, funct and immediate fields, and packs them into a 32-bit RV32I word. Writes the words sequentially into the instruction-memory write port. This is the producer end of the opcode/format contract that the core's main decoder consumes, and it covers exactly the six opcode classes that decoder recognises.

Parameters:
ADDR_W, 8, word-address width of the instruction-memory write port
DEPTH, 256, maximum number of words loaded per session (1..2**ADDR_W)
BASE_ADDR, 0, word address of the first write after start_i

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
start_i  in  1  one-cycle pulse: clear the write counter and done_o, begin a new session
valid_i  in  1  instruction fields valid
ready_o  out  1  block can accept fields this cycle
fmt_i  in  3  0=R(0110011) 1=LOAD(0000011) 2=STORE(0100011) 3=BRANCH(1100011) 4=IALU(0010011) 5=JAL(1101111); 6,7 illegal
rd_i  in  5  destination register
rs1_i  in  5  source register 1
rs2_i  in  5  source register 2
funct3_i  in  3  funct3 field
funct7_i  in  7  funct7 field (R only)
imm_i  in  32  byte immediate/offset, two's complement
we_o  out  1  imem write request
waddr_o  out  ADDR_W  imem word address
wdata_o  out  32  encoded instruction word
mem_ready_i  in  1  imem accepts the write this cycle
count_o  out  ADDR_W+1  words written this session
full_o  out  1  count_o == DEPTH
err_o  out  1  one-cycle pulse: input rejected
done_o  out  1  sticky: set when count_o reaches DEPTH, cleared by start_i or rst_i

Behaviour:
- Reset: we_o=0, waddr_o=BASE_ADDR, wdata_o=0, count_o=0, full_o=0, err_o=0, done_o=0. Any pending word is discarded. Reset mid-write aborts the write with no memory side effect required.
- Encoding (combinational from inputs; field bits from imm_i):
  - R: funct7|rs2|rs1|f3|rd|op
  - LOAD/IALU: imm[11:0]|rs1|f3|rd|op
  - STORE: imm[11:5]|rs2|rs1|f3|imm[4:0]|op
  - BRANCH: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
  - JAL: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
  - Higher imm bits are truncated without a range check.
- Rejection: fmt_i in {6,7}, or BRANCH/JAL with imm_i[0]=1.
  - On an accepted beat that is rejected: err_o pulses the next cycle, nothing is written, and the counter does not change.
- Pipeline: one-entry output register (pending).
  - An accept (valid_i & ready_o) in cycle N loads wdata_o and asserts we_o in cycle N+1, at waddr_o = BASE_ADDR + count_o.
  - Latency is 1 cycle.
- Write handshake:
  - The write completes in a cycle where we_o & mem_ready_i; count_o increments and waddr_o advances by 1.
  - While mem_ready_i=0, we_o, waddr_o and wdata_o hold stable.
- ready_o = !full_o & !start_i & (!we_o | mem_ready_i). A new accept in the same cycle as a completing write gives back-to-back writes, one per cycle.
- FSM states:
  - IDLE: after reset or when full. ready_o=0 until start_i.
  - LOAD: accepting.
  - FULL: count_o==DEPTH; done_o=1, full_o=1.
  - Transitions: IDLE --start_i--> LOAD; LOAD --last write completes--> FULL; FULL --start_i--> LOAD.
  - start_i while a write is pending: the pending write still completes at its current address, then the counter is cleared. count_o, done_o and full_o take their cleared values in the cycle after that write completes. If no write is pending, the clear happens the cycle after start_i.
- Counter: count_o is ADDR_W+1 bits and never exceeds DEPTH. waddr_o wraps modulo 2**ADDR_W from BASE_ADDR.

Test Plan:
- Reset, start_i, R fmt rd=3 rs1=1 rs2=2 f3=0 f7=0 -> next cycle we_o=1 waddr_o=0 wdata_o=0x002081B3; count_o=1 after mem_ready_i.
- IALU rd=5 rs1=0 imm=-1 -> wdata_o=0xFFF00293. STORE rs1=1 rs2=2 f3=2 imm=8 -> 0x0020A423. BRANCH rs1=1 rs2=2 f3=0 imm=-4 -> 0xFE208EE3. JAL rd=1 imm=8 -> 0x008000EF.
- Hold mem_ready_i=0 for 3 cycles with valid_i=1 -> ready_o=0, we_o/waddr_o/wdata_o stable; on release, back-to-back writes at consecutive addresses.
- fmt_i=7, and BRANCH with imm=3 -> err_o pulses once each, no we_o, count_o unchanged.
- DEPTH=4: stream 5 valid beats -> 4 writes to addresses 0..3, done_o=1, full_o=1, ready_o=0, fifth beat never accepted; start_i -> count_o=0, ready_o=1.
- Assert rst_i while we_o=1 and mem_ready_i=0 -> next cycle all outputs at reset values, IDLE.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// RV32I instruction encoder and sequential instruction-memory loader.
// Packs format/field beats into 32-bit words and writes them through a one-entry output register.
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        fmt_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [31:0]       imm_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [31:0]       wdata_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              err_o,
  output logic              done_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL} state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              clr_pend_q, clr_pend_d;

  logic [31:0]       enc;
  logic              rej;
  logic              stall, wr_done, clear_now, room, accept;
  logic [ADDR_W+1:0] outstanding;
  logic              unused_imm;

  assign unused_imm = ^imm_i[31:21];

  always_comb begin
    enc = '0;
    rej = 1'b0;
    case (fmt_i)
      3'd0: enc = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, 7'b0110011};
      3'd1: enc = {imm_i[11:0], rs1_i, funct3_i, rd_i, 7'b0000011};
      3'd2: enc = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], 7'b0100011};
      3'd3: begin
        enc = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], 7'b1100011};
        rej = imm_i[0];
      end
      3'd4: enc = {imm_i[11:0], rs1_i, funct3_i, rd_i, 7'b0010011};
      3'd5: begin
        enc = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, 7'b1101111};
        rej = imm_i[0];
      end
      default: rej = 1'b1;
    endcase
  end

  assign stall       = we_q & ~mem_ready_i;
  assign wr_done     = we_q & mem_ready_i;
  // A start that arrives while the pending write is stalled is remembered until that write lands.
  assign clear_now   = (start_i | clr_pend_q) & ~stall;
  // Count the in-flight word too, so the session never accepts more than DEPTH words.
  assign outstanding = {1'b0, count_q} + (ADDR_W+2)'(we_q);
  assign room        = outstanding < {1'b0, DEPTH_C};
  assign accept      = valid_i & ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      count_q    <= count_d;
      err_q      <= err_d;
      clr_pend_q <= clr_pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (clear_now) state_d = S_LOAD;
      S_LOAD: begin
        if (clear_now)
          state_d = S_LOAD;
        else if (wr_done && (count_q + 1'b1) == DEPTH_C)
          state_d = S_FULL;
      end
      S_FULL: if (clear_now) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state_q == S_LOAD) & ~full_o & ~start_i & ~stall & room;
    done_o  = (state_q == S_FULL);
    full_o  = (count_q == DEPTH_C);
  end

  always_comb begin
    we_d       = we_q;
    wdata_d    = wdata_q;
    count_d    = count_q;
    err_d      = 1'b0;
    clr_pend_d = clr_pend_q;
    if (wr_done) begin
      we_d    = 1'b0;
      count_d = count_q + 1'b1;
    end
    if (accept && !rej) begin
      we_d    = 1'b1;
      wdata_d = enc;
    end
    if (accept && rej)
      err_d = 1'b1;
    if (clear_now) begin
      count_d    = '0;
      clr_pend_d = 1'b0;
    end else if (start_i) begin
      clr_pend_d = 1'b1;
    end
  end

  assign we_o    = we_q;
  assign waddr_o = BASE_C + count_q[ADDR_W-1:0];
  assign wdata_o = wdata_q;
  assign count_o = count_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed encodings, handshake corner cases,
// a queue-based random scoreboard, and a DEPTH=4 instance for the full/done boundary.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst, start, valid, mem_ready;
  logic [2:0]  fmt, f3;
  logic [4:0]  rd, rs1, rs2;
  logic [6:0]  f7;
  logic [31:0] imm;

  logic        ready, we, err, done, full;
  logic [7:0]  waddr;
  logic [31:0] wdata;
  logic [8:0]  count;
  logic        ready4, we4, err4, done4, full4;
  logic [7:0]  waddr4;
  logic [31:0] wdata4;
  logic [8:0]  count4;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cnt = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(256), .BASE_ADDR(0)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .valid_i(valid), .ready_o(ready),
    .fmt_i(fmt), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .funct3_i(f3), .funct7_i(f7),
    .imm_i(imm), .we_o(we), .waddr_o(waddr), .wdata_o(wdata), .mem_ready_i(mem_ready),
    .count_o(count), .full_o(full), .err_o(err), .done_o(done)
  );

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(0)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .valid_i(valid), .ready_o(ready4),
    .fmt_i(fmt), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .funct3_i(f3), .funct7_i(f7),
    .imm_i(imm), .we_o(we4), .waddr_o(waddr4), .wdata_o(wdata4), .mem_ready_i(mem_ready),
    .count_o(count4), .full_o(full4), .err_o(err4), .done_o(done4)
  );

  // Reference encoder: each field is extracted with shifts/masks and placed by bit position.
  function automatic logic [31:0] ref_enc(input logic [2:0] f, input logic [4:0] d,
                                          input logic [4:0] s1, input logic [4:0] s2,
                                          input logic [2:0] fn3, input logic [6:0] fn7,
                                          input logic [31:0] im);
    logic [31:0] base;
    base = (32'(s1) << 15) | (32'(fn3) << 12);
    case (f)
      3'd0: return (32'(fn7) << 25) | (32'(s2) << 20) | base | (32'(d) << 7) | 32'd51;
      3'd1: return ((im & 32'hFFF) << 20) | base | (32'(d) << 7) | 32'd3;
      3'd2: return (((im >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | base | ((im & 32'h1F) << 7) | 32'd35;
      3'd3: return (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (32'(s2) << 20) | base
                   | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | 32'd99;
      3'd4: return ((im & 32'hFFF) << 20) | base | (32'(d) << 7) | 32'd19;
      3'd5: return (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21) | (((im >> 11) & 32'h1) << 20)
                   | (((im >> 12) & 32'hFF) << 12) | (32'(d) << 7) | 32'd111;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_rej(input logic [2:0] f, input logic [31:0] im);
    return (f > 3'd5) || ((f == 3'd3 || f == 3'd5) && im[0]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int f, input int d, input int s1, input int s2,
                      input int fn3, input int fn7, input logic [31:0] im);
    fmt = 3'(f); rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2);
    f3 = 3'(fn3); f7 = 7'(fn7); imm = im;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; valid = 1'b0; mem_ready = 1'b0;
    beat(0, 0, 0, 0, 0, 0, 32'd0);
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    total_cnt++; if (we !== 1'b0) $display("FAIL reset_we got=%0b want=0", we); else pass_cnt++;
    total_cnt++; if (waddr !== 8'd0) $display("FAIL reset_waddr got=%0h want=0", waddr); else pass_cnt++;
    total_cnt++; if (wdata !== 32'd0) $display("FAIL reset_wdata got=%h want=0", wdata); else pass_cnt++;
    total_cnt++; if (count !== 9'd0) $display("FAIL reset_count got=%0d want=0", count); else pass_cnt++;
    total_cnt++; if (full !== 1'b0) $display("FAIL reset_full got=%0b want=0", full); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL reset_err got=%0b want=0", err); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got=%0b want=0", done); else pass_cnt++;
    total_cnt++; if (ready !== 1'b0) $display("FAIL reset_ready_idle got=%0b want=0", ready); else pass_cnt++;
  endtask

  task automatic test_encode();
    int          vf[5]   = '{0, 4, 2, 3, 5};
    int          vrd[5]  = '{3, 5, 0, 0, 1};
    int          vs1[5]  = '{1, 0, 1, 1, 0};
    int          vs2[5]  = '{2, 0, 2, 2, 0};
    int          vf3[5]  = '{0, 0, 2, 0, 0};
    logic [31:0] vimm[5] = '{32'd0, 32'hFFFF_FFFF, 32'd8, 32'hFFFF_FFFC, 32'd8};
    logic [31:0] vexp[5] = '{32'h002081B3, 32'hFFF00293, 32'h0020A423, 32'hFE208EE3, 32'h008000EF};
    start = 1'b1; tick(); start = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    total_cnt++; if (ready !== 1'b1) $display("FAIL start_ready got=%0b want=1", ready); else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      beat(vf[k], vrd[k], vs1[k], vs2[k], vf3[k], 0, vimm[k]);
      valid = 1'b1;
      tick();
      valid = 1'b0;
      @(negedge clk);
      total_cnt++; if (we !== 1'b1) $display("FAIL enc_we[%0d] got=%0b want=1", k, we); else pass_cnt++;
      total_cnt++; if (waddr !== 8'(k)) $display("FAIL enc_waddr[%0d] got=%0d want=%0d", k, waddr, k); else pass_cnt++;
      total_cnt++; if (wdata !== vexp[k]) $display("FAIL enc_wdata[%0d] got=%h want=%h", k, wdata, vexp[k]); else pass_cnt++;
      tick();
      @(negedge clk);
      total_cnt++; if (count !== 9'(k + 1)) $display("FAIL enc_count[%0d] got=%0d want=%0d", k, count, k + 1); else pass_cnt++;
      total_cnt++; if (we !== 1'b0) $display("FAIL enc_we_clear[%0d] got=%0b want=0", k, we); else pass_cnt++;
    end
    cnt = 5;
  endtask

  task automatic test_back_to_back();
    logic [31:0] wa, wb;
    beat(4, 7, 2, 0, 0, 0, 32'h123);
    wa = ref_enc(3'd4, 5'd7, 5'd2, 5'd0, 3'd0, 7'd0, 32'h123);
    valid = 1'b1; mem_ready = 1'b0;
    tick();
    beat(0, 9, 10, 11, 1, 32, 32'd0);
    wb = ref_enc(3'd0, 5'd9, 5'd10, 5'd11, 3'd1, 7'd32, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++; if (ready !== 1'b0) $display("FAIL stall_ready[%0d] got=%0b want=0", i, ready); else pass_cnt++;
      total_cnt++; if (we !== 1'b1) $display("FAIL stall_we[%0d] got=%0b want=1", i, we); else pass_cnt++;
      total_cnt++; if (waddr !== 8'(cnt)) $display("FAIL stall_waddr[%0d] got=%0d want=%0d", i, waddr, cnt); else pass_cnt++;
      total_cnt++; if (wdata !== wa) $display("FAIL stall_wdata[%0d] got=%h want=%h", i, wdata, wa); else pass_cnt++;
      tick();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    total_cnt++; if (ready !== 1'b1) $display("FAIL release_ready got=%0b want=1", ready); else pass_cnt++;
    tick();
    valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (we !== 1'b1) $display("FAIL b2b_we got=%0b want=1", we); else pass_cnt++;
    total_cnt++; if (waddr !== 8'(cnt + 1)) $display("FAIL b2b_waddr got=%0d want=%0d", waddr, cnt + 1); else pass_cnt++;
    total_cnt++; if (wdata !== wb) $display("FAIL b2b_wdata got=%h want=%h", wdata, wb); else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++; if (count !== 9'(cnt + 2)) $display("FAIL b2b_count got=%0d want=%0d", count, cnt + 2); else pass_cnt++;
    cnt = cnt + 2;
  endtask

  task automatic test_reject();
    logic [2:0]  rf[2]   = '{3'd7, 3'd3};
    logic [31:0] rimm[2] = '{32'd0, 32'd3};
    mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      beat(int'(rf[k]), 1, 1, 2, 0, 0, rimm[k]);
      valid = 1'b1;
      tick();
      valid = 1'b0;
      @(negedge clk);
      total_cnt++; if (err !== 1'b1) $display("FAIL rej_err[%0d] got=%0b want=1", k, err); else pass_cnt++;
      total_cnt++; if (we !== 1'b0) $display("FAIL rej_we[%0d] got=%0b want=0", k, we); else pass_cnt++;
      total_cnt++; if (count !== 9'(cnt)) $display("FAIL rej_count[%0d] got=%0d want=%0d", k, count, cnt); else pass_cnt++;
      tick();
      @(negedge clk);
      total_cnt++; if (err !== 1'b0) $display("FAIL rej_err_pulse[%0d] got=%0b want=0", k, err); else pass_cnt++;
    end
  endtask

  task automatic test_start_pending();
    logic [31:0] wx;
    beat(1, 4, 3, 0, 2, 0, 32'h7F0);
    wx = ref_enc(3'd1, 5'd4, 5'd3, 5'd0, 3'd2, 7'd0, 32'h7F0);
    valid = 1'b1; mem_ready = 1'b0;
    tick();
    valid = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    total_cnt++; if (we !== 1'b1) $display("FAIL sp_we got=%0b want=1", we); else pass_cnt++;
    total_cnt++; if (waddr !== 8'(cnt)) $display("FAIL sp_waddr got=%0d want=%0d", waddr, cnt); else pass_cnt++;
    total_cnt++; if (wdata !== wx) $display("FAIL sp_wdata got=%h want=%h", wdata, wx); else pass_cnt++;
    total_cnt++; if (count !== 9'(cnt)) $display("FAIL sp_count_hold got=%0d want=%0d", count, cnt); else pass_cnt++;
    mem_ready = 1'b1;
    tick();
    @(negedge clk);
    total_cnt++; if (count !== 9'd0) $display("FAIL sp_count_clear got=%0d want=0", count); else pass_cnt++;
    total_cnt++; if (we !== 1'b0) $display("FAIL sp_we_clear got=%0b want=0", we); else pass_cnt++;
    total_cnt++; if (ready !== 1'b1) $display("FAIL sp_ready got=%0b want=1", ready); else pass_cnt++;
    cnt = 0;
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    int          count_m = 0;
    logic        err_m = 1'b0;
    logic        rdy_m, rj;
    rst = 1'b1; valid = 1'b0; tick(); rst = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      valid = 1'($urandom_range(0, 1));
      mem_ready = ($urandom_range(0, 3) != 0);
      fmt = 3'($urandom_range(0, 7)); rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      f3 = 3'($urandom); f7 = 7'($urandom); imm = $urandom;
      if ($urandom_range(0, 3) != 0) imm[0] = 1'b0;
      @(negedge clk);
      rdy_m = (count_m + q.size() < 256) && !(q.size() != 0 && !mem_ready);
      total_cnt++; if (ready !== rdy_m) $display("FAIL rnd_ready c=%0d got=%0b want=%0b", c, ready, rdy_m); else pass_cnt++;
      total_cnt++; if (we !== (q.size() != 0)) $display("FAIL rnd_we c=%0d got=%0b want=%0b", c, we, q.size() != 0); else pass_cnt++;
      if (q.size() != 0) begin
        total_cnt++; if (wdata !== q[0]) $display("FAIL rnd_wdata c=%0d got=%h want=%h", c, wdata, q[0]); else pass_cnt++;
        total_cnt++; if (waddr !== 8'(count_m)) $display("FAIL rnd_waddr c=%0d got=%0d want=%0d", c, waddr, count_m); else pass_cnt++;
      end
      total_cnt++; if (err !== err_m) $display("FAIL rnd_err c=%0d got=%0b want=%0b", c, err, err_m); else pass_cnt++;
      total_cnt++; if (count !== 9'(count_m)) $display("FAIL rnd_count c=%0d got=%0d want=%0d", c, count, count_m); else pass_cnt++;
      total_cnt++; if (full !== (count_m == 256)) $display("FAIL rnd_full c=%0d got=%0b want=%0b", c, full, count_m == 256); else pass_cnt++;
      rj = ref_rej(fmt, imm);
      err_m = valid && rdy_m && rj;
      if (q.size() != 0 && mem_ready) begin
        void'(q.pop_front());
        count_m++;
      end
      if (valid && rdy_m && !rj) q.push_back(ref_enc(fmt, rd, rs1, rs2, f3, f7, imm));
      tick();
    end
    valid = 1'b0;
  endtask

  task automatic test_depth();
    int b = 0;
    int writes = 0;
    rst = 1'b1; valid = 1'b0; tick(); rst = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    mem_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      beat(4, b + 1, 0, 0, 0, 0, 32'(b * 4));
      valid = (b < 5);
      @(negedge clk);
      if (we4) begin
        total_cnt++;
        if (waddr4 !== 8'(writes)) $display("FAIL depth_waddr[%0d] got=%0d want=%0d", writes, waddr4, writes); else pass_cnt++;
        total_cnt++;
        if (wdata4 !== ref_enc(3'd4, 5'(writes + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(writes * 4)))
          $display("FAIL depth_wdata[%0d] got=%h want=%h", writes, wdata4,
                   ref_enc(3'd4, 5'(writes + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(writes * 4)));
        else pass_cnt++;
        writes++;
      end
      if (valid && ready4) b++;
      tick();
    end
    @(negedge clk);
    total_cnt++; if (writes != 4) $display("FAIL depth_writes got=%0d want=4", writes); else pass_cnt++;
    total_cnt++; if (b != 4) $display("FAIL depth_accepts got=%0d want=4", b); else pass_cnt++;
    total_cnt++; if (count4 !== 9'd4) $display("FAIL depth_count got=%0d want=4", count4); else pass_cnt++;
    total_cnt++; if (done4 !== 1'b1) $display("FAIL depth_done got=%0b want=1", done4); else pass_cnt++;
    total_cnt++; if (full4 !== 1'b1) $display("FAIL depth_full got=%0b want=1", full4); else pass_cnt++;
    total_cnt++; if (ready4 !== 1'b0) $display("FAIL depth_ready got=%0b want=0", ready4); else pass_cnt++;
    valid = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    total_cnt++; if (count4 !== 9'd0) $display("FAIL restart_count got=%0d want=0", count4); else pass_cnt++;
    total_cnt++; if (ready4 !== 1'b1) $display("FAIL restart_ready got=%0b want=1", ready4); else pass_cnt++;
    total_cnt++; if (done4 !== 1'b0) $display("FAIL restart_done got=%0b want=0", done4); else pass_cnt++;
    total_cnt++; if (full4 !== 1'b0) $display("FAIL restart_full got=%0b want=0", full4); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; tick(); rst = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    beat(0, 3, 1, 2, 0, 0, 32'd0);
    valid = 1'b1; mem_ready = 1'b0;
    tick();
    valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (we !== 1'b1) $display("FAIL rmid_pending got=%0b want=1", we); else pass_cnt++;
    rst = 1'b1;
    tick();
    @(negedge clk);
    total_cnt++; if (we !== 1'b0) $display("FAIL rmid_we got=%0b want=0", we); else pass_cnt++;
    total_cnt++; if (waddr !== 8'd0) $display("FAIL rmid_waddr got=%0d want=0", waddr); else pass_cnt++;
    total_cnt++; if (wdata !== 32'd0) $display("FAIL rmid_wdata got=%h want=0", wdata); else pass_cnt++;
    total_cnt++; if (count !== 9'd0) $display("FAIL rmid_count got=%0d want=0", count); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL rmid_err got=%0b want=0", err); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL rmid_done got=%0b want=0", done); else pass_cnt++;
    total_cnt++; if (full !== 1'b0) $display("FAIL rmid_full got=%0b want=0", full); else pass_cnt++;
    total_cnt++; if (ready !== 1'b0) $display("FAIL rmid_ready got=%0b want=0", ready); else pass_cnt++;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_encode();
    test_back_to_back();
    test_reject();
    test_start_pending();
    test_random();
    test_depth();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
